// File: rtl/eth400_pkg.sv
// Shared eth400 definitions used by the TX arbiter and the 400G adapter.
//   ETH_DATA_W / ETH_KEEP_W : default AXIS data / byte-enable widths
//   axis_tx_t               : one AXIS TX beat as exchanged with the adapter
//   arb_state_e             : TX arbiter lock state
//   idx_w()                 : index width for an N-entry vector (min 1 bit)
package eth400_pkg;

   localparam int unsigned ETH_DATA_W = 1024;
   localparam int unsigned ETH_KEEP_W = ETH_DATA_W / 8;

   typedef struct packed {
      logic [ETH_DATA_W-1:0] tdata;
      logic [ETH_KEEP_W-1:0] tkeep;
      logic                  tlast;
      logic                  tuser;
   } axis_tx_t;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_e;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/eth400_rr_pick.sv
// Combinational round-robin priority selector.
//   req   : request vector
//   ptr   : index holding highest priority this cycle
//   grant : one-hot grant of the first requester at or after ptr (cyclic)
//   valid : any request present
module eth400_rr_pick
   import eth400_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic             valid
);

   int unsigned idx;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      for (int unsigned off = 0; off < N; off++) begin
         idx = (32'(ptr) + off) % N;
         if (!valid && req[IDX_W'(idx)]) begin
            grant[IDX_W'(idx)] = 1'b1;
            valid              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eth400_tx_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC CASPER TX AXIS streams
// into one stream for the 400G adapter, with one output register stage.
//   s_tdata/s_tkeep/s_tvalid/s_tlast/s_tuser : per-source AXIS input (slice i)
//   s_tready : per-source ready (only the locked source may see it high)
//   src_en   : per-source arbitration enable (does not abort a packet)
//   m_*      : arbitrated AXIS output, m_tready downstream ready
//   grant_id : current/last granted source
//   busy     : a packet is locked
//   pkt_cnt  : delivered tlast beats, wrapping
module eth400_tx_arbiter
   import eth400_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned DATA_W  = ETH_DATA_W,
   parameter int unsigned KEEP_W  = ETH_KEEP_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_SRC*DATA_W-1:0]   s_tdata,
   input  logic [NUM_SRC*KEEP_W-1:0]   s_tkeep,
   input  logic [NUM_SRC-1:0]          s_tvalid,
   input  logic [NUM_SRC-1:0]          s_tlast,
   input  logic [NUM_SRC-1:0]          s_tuser,
   output logic [NUM_SRC-1:0]          s_tready,
   input  logic [NUM_SRC-1:0]          src_en,
   output logic [DATA_W-1:0]           m_tdata,
   output logic [KEEP_W-1:0]           m_tkeep,
   output logic                        m_tvalid,
   output logic                        m_tlast,
   output logic                        m_tuser,
   input  logic                        m_tready,
   output logic [idx_w(NUM_SRC)-1:0]   grant_id,
   output logic                        busy,
   output logic [31:0]                 pkt_cnt
);

   localparam int unsigned IDX_W = idx_w(NUM_SRC);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [NUM_SRC-1:0] req, pick_grant;
   logic              pick_valid;
   logic [IDX_W-1:0]  pick_idx;
   logic              out_ready, acc, acc_last;
   logic [31:0]       pkt_cnt_q;

   assign req = s_tvalid & src_en;

   eth400_rr_pick #(.N(NUM_SRC), .IDX_W(IDX_W)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .valid (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (pick_grant[i]) pick_idx = IDX_W'(i);
      end
   end

   // The output register can take a beat when empty or being drained.
   assign out_ready = ~m_tvalid | m_tready;
   assign acc       = (state_q == ARB_LOCKED) & s_tvalid[grant_q] & out_ready;
   assign acc_last  = acc & s_tlast[grant_q];

   always_comb begin
      s_tready = '0;
      if (state_q == ARB_LOCKED) s_tready[grant_q] = out_ready;
   end

   // The requesting set seen on the tlast cycle still contains the current
   // source (its last beat is valid), so a sole requester re-locks itself and
   // a back-to-back packet follows without a bubble.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_d = ARB_LOCKED;
               grant_d = pick_idx;
               ptr_d   = (pick_idx == IDX_W'(NUM_SRC - 1)) ? '0 : pick_idx + 1'b1;
            end
         end
         ARB_LOCKED: begin
            if (acc_last) begin
               if (pick_valid) begin
                  grant_d = pick_idx;
                  ptr_d   = (pick_idx == IDX_W'(NUM_SRC - 1)) ? '0 : pick_idx + 1'b1;
               end else begin
                  state_d = ARB_IDLE;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         m_tuser  <= 1'b0;
         m_tdata  <= '0;
         m_tkeep  <= '0;
      end else if (out_ready) begin
         m_tvalid <= acc;
         if (acc) begin
            m_tdata <= s_tdata[grant_q*DATA_W +: DATA_W];
            m_tkeep <= s_tkeep[grant_q*KEEP_W +: KEEP_W];
            m_tlast <= s_tlast[grant_q];
            m_tuser <= s_tuser[grant_q];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_cnt_q <= '0;
      end else if (m_tvalid && m_tready && m_tlast) begin
         pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
   end

   assign pkt_cnt  = pkt_cnt_q;
   assign grant_id = grant_q;
   assign busy     = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_eth400_tx_arbiter.sv
// Scoreboard bench for eth400_tx_arbiter: packet order predicted by a
// round-robin model over pending packet counts, compared beat-by-beat.
module tb_eth400_tx_arbiter;

   localparam int NSRC = 4;
   localparam int DW   = 64;
   localparam int KW   = 8;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NSRC*DW-1:0]   s_tdata = '0;
   logic [NSRC*KW-1:0]   s_tkeep = '0;
   logic [NSRC-1:0]      s_tvalid = '0, s_tlast = '0, s_tuser = '0;
   logic [NSRC-1:0]      s_tready;
   logic [NSRC-1:0]      src_en = '1;
   logic [DW-1:0]        m_tdata;
   logic [KW-1:0]        m_tkeep;
   logic                 m_tvalid, m_tlast, m_tuser;
   logic                 m_tready = 1'b1;
   logic [1:0]           grant_id;
   logic                 busy;
   logic [31:0]          pkt_cnt;

   eth400_tx_arbiter #(.NUM_SRC(NSRC), .DATA_W(DW), .KEEP_W(KW)) dut (
      .clk(clk), .rst(rst),
      .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
      .s_tlast(s_tlast), .s_tuser(s_tuser), .s_tready(s_tready),
      .src_en(src_en),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
      .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tready(m_tready),
      .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
      logic          u;
   } beat_t;

   beat_t stim_q[NSRC][$];
   beat_t exp_q[$];
   int    checks = 0, errors = 0;
   int    cyc = 0;
   int    mon_beats = 0;
   int    first_cyc = -1, last_cyc = -1;
   int    pend[NSRC];
   logic [NSRC-1:0] drv_acc;
   logic  stall_prev = 1'b0;
   beat_t hold;
   logic [31:0] exp_cnt;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic present();
      for (int i = 0; i < NSRC; i++) begin
         if (stim_q[i].size() > 0) begin
            s_tvalid[i]            = 1'b1;
            s_tdata[i*DW +: DW]    = stim_q[i][0].d;
            s_tkeep[i*KW +: KW]    = stim_q[i][0].k;
            s_tlast[i]             = stim_q[i][0].l;
            s_tuser[i]             = stim_q[i][0].u;
         end else begin
            s_tvalid[i] = 1'b0;
         end
      end
   endtask

   task automatic flush();
      for (int i = 0; i < NSRC; i++) stim_q[i].delete();
      exp_q.delete();
      present();
   endtask

   // Source driver: handshake observed mid-cycle, queue advanced after the edge.
   initial begin
      forever begin
         @(negedge clk);
         drv_acc = s_tvalid & s_tready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NSRC; i++)
            if (drv_acc[i] && stim_q[i].size() > 0) void'(stim_q[i].pop_front());
         present();
      end
   end

   // Monitor: pops the scoreboard on every accepted output beat.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               checks++;
               if (m_tvalid !== 1'b1 || m_tdata !== hold.d || m_tkeep !== hold.k ||
                   m_tlast !== hold.l || m_tuser !== hold.u) begin
                  errors++;
                  $display("FAIL stall_hold: got v=%0b d=%0h expected v=1 d=%0h", m_tvalid, m_tdata, hold.d);
               end
            end
            if (m_tvalid && m_tready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat: got d=%0h expected no beat", m_tdata);
               end else begin
                  beat_t e;
                  e = exp_q.pop_front();
                  if (m_tdata !== e.d || m_tkeep !== e.k || m_tlast !== e.l || m_tuser !== e.u) begin
                     errors++;
                     $display("FAIL beat: got d=%0h k=%0h l=%0b u=%0b expected d=%0h k=%0h l=%0b u=%0b",
                              m_tdata, m_tkeep, m_tlast, m_tuser, e.d, e.k, e.l, e.u);
                  end
               end
               mon_beats++;
               if (first_cyc < 0) first_cyc = cyc;
               last_cyc = cyc;
            end
            stall_prev = m_tvalid && !m_tready;
            hold.d = m_tdata; hold.k = m_tkeep; hold.l = m_tlast; hold.u = m_tuser;
         end
      end
   end

   task automatic add_pkt(input int src, input int len, input bit expect_out);
      beat_t b;
      for (int j = 0; j < len; j++) begin
         b.d = {$urandom, $urandom};
         b.k = 8'($urandom);
         b.l = (j == len - 1);
         b.u = 1'($urandom);
         stim_q[src].push_back(b);
         if (expect_out) exp_q.push_back(b);
      end
   endtask

   // Round-robin model: next owner is the first source with pending packets
   // at or after the pointer; pointer moves past each owner.
   task automatic load_rr(input int len_fixed);
      int ptr, s, left;
      ptr = 0;
      left = 0;
      for (int i = 0; i < NSRC; i++) left += pend[i];
      exp_cnt = 32'(left);
      while (left > 0) begin
         s = -1;
         for (int off = 0; off < NSRC && s < 0; off++)
            if (pend[(ptr + off) % NSRC] > 0) s = (ptr + off) % NSRC;
         add_pkt(s, (len_fixed > 0) ? len_fixed : int'($urandom_range(1, 4)), 1'b1);
         pend[s]--;
         left--;
         ptr = (s + 1) % NSRC;
      end
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      flush();
      m_tready = 1'b1;
      src_en = '1;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      mon_beats = 0;
      first_cyc = -1;
      last_cyc = -1;
      for (int i = 0; i < NSRC; i++) pend[i] = 0;
   endtask

   task automatic drain(input bit rand_ready);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 2000) begin
         @(posedge clk);
         #1;
         if (rand_ready) m_tready = ($urandom % 4) != 0;
         n++;
      end
      check("drain_left", 64'(exp_q.size()), 0);
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_beats(input int n);
      int t;
      t = 0;
      while (mon_beats < n && t < 200) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("wait_beats", 64'(mon_beats >= n), 1);
   endtask

   initial begin
      // Reset values
      #23;
      check("rst_m_tvalid", 64'(m_tvalid), 0);
      check("rst_m_tlast",  64'(m_tlast), 0);
      check("rst_m_tuser",  64'(m_tuser), 0);
      check("rst_m_tdata",  64'(m_tdata), 0);
      check("rst_m_tkeep",  64'(m_tkeep), 0);
      check("rst_pkt_cnt",  64'(pkt_cnt), 0);
      check("rst_grant_id", 64'(grant_id), 0);
      check("rst_busy",     64'(busy), 0);
      check("rst_s_tready", 64'(s_tready), 0);

      // Four simultaneous 3-beat packets
      apply_reset();
      for (int i = 0; i < NSRC; i++) pend[i] = 1;
      load_rr(3);
      drain(1'b0);
      check("s1_contig", 64'(last_cyc - first_cyc), 11);
      check("s1_beats", 64'(mon_beats), 12);
      check("s1_pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt));
      check("s1_grant_id", 64'(grant_id), 3);

      // Source 1 back-to-back packets
      apply_reset();
      pend[1] = 2;
      load_rr(2);
      drain(1'b0);
      check("s2_contig", 64'(last_cyc - first_cyc), 3);
      check("s2_grant_id", 64'(grant_id), 1);
      check("s2_pkt_cnt", 64'(pkt_cnt), 2);

      // Downstream stall mid packet
      apply_reset();
      add_pkt(2, 4, 1'b1);
      wait_beats(2);
      @(posedge clk);
      #1;
      m_tready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("s3_s_tready2", 64'(s_tready[2]), 0);
         check("s3_m_tvalid", 64'(m_tvalid), 1);
      end
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      drain(1'b0);
      check("s3_beats", 64'(mon_beats), 4);
      check("s3_pkt_cnt", 64'(pkt_cnt), 1);

      // src_en drop mid packet
      apply_reset();
      add_pkt(0, 5, 1'b1);
      add_pkt(3, 2, 1'b1);
      add_pkt(0, 2, 1'b0);
      wait_beats(1);
      src_en[0] = 1'b0;
      drain(1'b0);
      repeat (20) @(posedge clk);
      #1;
      check("s4_beats", 64'(mon_beats), 7);
      check("s4_grant_id", 64'(grant_id), 3);
      check("s4_pkt_cnt", 64'(pkt_cnt), 2);
      check("s4_s_tready0", 64'(s_tready[0]), 0);

      // Reset mid packet
      apply_reset();
      add_pkt(1, 4, 1'b1);
      wait_beats(1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      flush();
      #1;
      check("s5_m_tvalid", 64'(m_tvalid), 0);
      check("s5_pkt_cnt", 64'(pkt_cnt), 0);
      check("s5_s_tready", 64'(s_tready), 0);
      check("s5_busy", 64'(busy), 0);
      check("s5_grant_id", 64'(grant_id), 0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b0;
      mon_beats = 0;
      pend[0] = 1;
      pend[1] = 1;
      load_rr(2);
      @(negedge clk);
      #1;
      wait_beats(1);
      check("s5_first_grant", 64'(grant_id), 0);
      drain(1'b0);
      check("s5_pkt_cnt_after", 64'(pkt_cnt), 2);

      // pkt_cnt wrap
      apply_reset();
      force dut.pkt_cnt_q = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      release dut.pkt_cnt_q;
      exp_cnt = 32'hFFFF_FFFF;
      exp_cnt = exp_cnt + 32'd1;
      add_pkt(2, 2, 1'b1);
      drain(1'b0);
      check("s6_pkt_wrap", 64'(pkt_cnt), 64'(exp_cnt));

      // Randomized packet mixes with random downstream backpressure
      for (int r = 0; r < 4; r++) begin
         apply_reset();
         for (int i = 0; i < NSRC; i++) pend[i] = $urandom_range(0, 2);
         if (pend[0] + pend[1] + pend[2] + pend[3] == 0) pend[0] = 1;
         load_rr(0);
         drain(1'b1);
         check("rnd_pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
